// File: rtl/vga_timing_pkg.sv
// ============================================================================
//  Module      : vga_timing_pkg
//  Description : Shared 640x480@60 timing constants, receiver FSM encoding
//                and CRC-16-CCITT constants.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package vga_timing_pkg;

    localparam int CLKS_PER_PIX = 4;

    localparam int H_TOTAL      = 800;
    localparam int H_SYNC       = 96;
    localparam int H_VIS_START  = 144;
    localparam int H_VIS        = 640;

    localparam int V_TOTAL      = 525;
    localparam int V_SYNC       = 2;
    localparam int V_VIS_START  = 35;
    localparam int V_VIS        = 480;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_SEED = 16'hFFFF;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } rx_state_e;

endpackage

`default_nettype wire

// File: rtl/vga_rx_crc16.sv
// ============================================================================
//  Module      : vga_rx_crc16
//  Description : One-step CRC-16-CCITT update over a 12-bit pixel, MSB first.
//                Present only when VGA_RX_CRC_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifdef VGA_RX_CRC_EN
module vga_rx_crc16
    import vga_timing_pkg::*;
(
    input  logic [15:0] i_crc,
    input  logic [11:0] i_data,
    output logic [15:0] o_crc
);

    logic [15:0] w_crc;
    logic        w_fb;

    always_comb begin
        w_crc = i_crc;
        w_fb  = 1'b0;
        for (int i = 11; i >= 0; i--) begin
            w_fb  = w_crc[15] ^ i_data[i];
            w_crc = {w_crc[14:0], 1'b0} ^ (w_fb ? CRC16_POLY : 16'h0000);
        end
        o_crc = w_crc;
    end

endmodule
`endif

`default_nettype wire

// File: rtl/vga_sync_receiver.sv
// ============================================================================
//  Module      : vga_sync_receiver
//  Description : Recovers pixel timing from hSync/vSync/RGB, locks to the
//                frame structure and samples visible pixels plus one probe.
//                Optional frame CRC output enabled by macro VGA_RX_CRC_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_sync_receiver
    import vga_timing_pkg::*;
#(
    parameter int CLKS_PER_PIX = vga_timing_pkg::CLKS_PER_PIX,
    parameter int SAMPLE_PHASE = 2,
    parameter int H_TOTAL      = vga_timing_pkg::H_TOTAL,
    parameter int H_VIS_START  = vga_timing_pkg::H_VIS_START,
    parameter int H_VIS        = vga_timing_pkg::H_VIS,
    parameter int V_TOTAL      = vga_timing_pkg::V_TOTAL,
    parameter int V_VIS_START  = vga_timing_pkg::V_VIS_START,
    parameter int V_VIS        = vga_timing_pkg::V_VIS
)(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        hSync,
    input  logic        vSync,
    input  logic [11:0] rgb_in,
    input  logic [9:0]  probe_x,
    input  logic [9:0]  probe_y,
    output logic        locked,
    output logic [9:0]  rx_hc,
    output logic [9:0]  rx_vc,
    output logic        rx_bright,
    output logic        pix_valid,
    output logic [11:0] pix_rgb,
    output logic        probe_valid,
    output logic [11:0] probe_rgb,
    output logic [15:0] frame_cnt,
    output logic [7:0]  err_cnt
`ifdef VGA_RX_CRC_EN
    ,
    output logic [15:0] frame_crc,
    output logic        crc_valid
`endif
);

    localparam int PH_W = (CLKS_PER_PIX > 1) ? $clog2(CLKS_PER_PIX) : 1;

    localparam logic [PH_W-1:0] PH_LAST   = PH_W'(CLKS_PER_PIX - 1);
    localparam logic [PH_W-1:0] PH_SAMPLE = PH_W'(SAMPLE_PHASE);
    localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_VS      = 10'(H_VIS_START);
    localparam logic [9:0]  H_VE      = 10'(H_VIS_START + H_VIS);
    localparam logic [9:0]  V_VS      = 10'(V_VIS_START);
    localparam logic [9:0]  V_VE      = 10'(V_VIS_START + V_VIS);
    localparam logic [10:0] H_OFF     = 11'(H_VIS_START);
    localparam logic [10:0] V_OFF     = 11'(V_VIS_START);
    localparam logic [9:0]  H_VIS_W   = 10'(H_VIS);
    localparam logic [9:0]  V_VIS_W   = 10'(V_VIS);

    logic            hs_q, vs_q, hs_prev_q, vs_prev_q;
    logic [11:0]     rgb_q;
    rx_state_e       state_q, state_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic [9:0]      hc_q, hc_d, vc_q, vc_d;
    logic            pix_valid_q, pix_valid_d, probe_valid_q, probe_valid_d;
    logic [11:0]     pix_rgb_q, pix_rgb_d, probe_rgb_q, probe_rgb_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;
    logic [7:0]      err_cnt_q, err_cnt_d;

    logic w_hs_fall, w_vs_fall, w_any_err, w_phase_wrap;
    logic w_bright, w_sample, w_probe_hit, w_lock_lost, w_frame_ok;

    always_comb begin
        w_hs_fall    = hs_prev_q & ~hs_q;
        w_vs_fall    = vs_prev_q & ~vs_q;
        w_any_err    = (w_hs_fall && (hc_q != H_LAST)) || (w_vs_fall && (vc_q != V_LAST));
        w_phase_wrap = (phase_q == PH_LAST);
        w_bright     = (state_q == LOCKED) && (hc_q >= H_VS) && (hc_q < H_VE)
                       && (vc_q >= V_VS) && (vc_q < V_VE);
        w_sample     = w_bright && (phase_q == PH_SAMPLE);
        // Range checks first so a wrapped probe+offset can never alias a visible pixel
        w_probe_hit  = w_sample && (probe_x < H_VIS_W) && (probe_y < V_VIS_W)
                       && ({1'b0, hc_q} == ({1'b0, probe_x} + H_OFF))
                       && ({1'b0, vc_q} == ({1'b0, probe_y} + V_OFF));
    end

    // Lock FSM
    always_comb begin
        state_d     = state_q;
        w_lock_lost = 1'b0;
        w_frame_ok  = 1'b0;
        case (state_q)
            HUNT: begin
                if (w_vs_fall) state_d = ACQUIRE;
            end
            ACQUIRE: begin
                if (w_any_err)      state_d = HUNT;
                else if (w_vs_fall) state_d = LOCKED;
            end
            LOCKED: begin
                if (w_any_err) begin
                    state_d     = HUNT;
                    w_lock_lost = 1'b1;
                end else if (w_vs_fall) begin
                    w_frame_ok  = 1'b1;
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_comb begin
        phase_d = w_phase_wrap ? '0 : phase_q + 1'b1;
        if (w_hs_fall) phase_d = '0;

        hc_d = hc_q;
        if (w_hs_fall)                         hc_d = '0;
        else if (w_phase_wrap && hc_q < H_LAST) hc_d = hc_q + 10'd1;

        // vSync fall takes priority over the line increment
        vc_d = vc_q;
        if (w_vs_fall)                      vc_d = '0;
        else if (w_hs_fall && vc_q < V_LAST) vc_d = vc_q + 10'd1;

        pix_valid_d   = w_sample;
        pix_rgb_d     = w_sample ? rgb_q : pix_rgb_q;
        probe_valid_d = w_probe_hit;
        probe_rgb_d   = w_probe_hit ? rgb_q : probe_rgb_q;

        frame_cnt_d = frame_cnt_q + {15'd0, w_frame_ok};
        err_cnt_d   = err_cnt_q;
        if (w_lock_lost && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            hs_prev_q     <= 1'b1;
            vs_prev_q     <= 1'b1;
            rgb_q         <= '0;
            state_q       <= HUNT;
            phase_q       <= '0;
            hc_q          <= '0;
            vc_q          <= '0;
            pix_valid_q   <= 1'b0;
            pix_rgb_q     <= '0;
            probe_valid_q <= 1'b0;
            probe_rgb_q   <= '0;
            frame_cnt_q   <= '0;
            err_cnt_q     <= '0;
        end else begin
            hs_q          <= hSync;
            vs_q          <= vSync;
            hs_prev_q     <= hs_q;
            vs_prev_q     <= vs_q;
            rgb_q         <= rgb_in;
            state_q       <= state_d;
            phase_q       <= phase_d;
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            pix_valid_q   <= pix_valid_d;
            pix_rgb_q     <= pix_rgb_d;
            probe_valid_q <= probe_valid_d;
            probe_rgb_q   <= probe_rgb_d;
            frame_cnt_q   <= frame_cnt_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign locked      = (state_q == LOCKED);
    assign rx_hc       = hc_q;
    assign rx_vc       = vc_q;
    assign rx_bright   = w_bright;
    assign pix_valid   = pix_valid_q;
    assign pix_rgb     = pix_rgb_q;
    assign probe_valid = probe_valid_q;
    assign probe_rgb   = probe_rgb_q;
    assign frame_cnt   = frame_cnt_q;
    assign err_cnt     = err_cnt_q;

`ifdef VGA_RX_CRC_EN
    logic [15:0] crc_acc_q, crc_acc_d, frame_crc_q, frame_crc_d, w_crc_next;
    logic        crc_valid_q, crc_valid_d;

    vga_rx_crc16 u_crc (
        .i_crc  (crc_acc_q),
        .i_data (rgb_q),
        .o_crc  (w_crc_next)
    );

    // Running CRC covers exactly the pixels that reach pix_rgb
    always_comb begin
        crc_acc_d   = crc_acc_q;
        frame_crc_d = frame_crc_q;
        crc_valid_d = 1'b0;
        if (w_lock_lost) begin
            crc_acc_d   = '0;
            frame_crc_d = '0;
        end else if (w_vs_fall) begin
            crc_acc_d = CRC16_SEED;
            if (w_frame_ok) begin
                frame_crc_d = crc_acc_q;
                crc_valid_d = 1'b1;
            end
        end else if (w_sample) begin
            crc_acc_d = w_crc_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_acc_q   <= '0;
            frame_crc_q <= '0;
            crc_valid_q <= 1'b0;
        end else begin
            crc_acc_q   <= crc_acc_d;
            frame_crc_q <= frame_crc_d;
            crc_valid_q <= crc_valid_d;
        end
    end

    assign frame_crc = frame_crc_q;
    assign crc_valid = crc_valid_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_receiver.sv
// ============================================================================
//  Module      : tb_vga_sync_receiver
//  Description : Directed bench for vga_sync_receiver using a scaled-down
//                20x12-pixel raster (4 clk/pixel) to keep runs short.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vga_sync_receiver;

    localparam int HT = 20, HVS = 5, HV = 12, VT = 12, VVS = 3, VV = 8, CPP = 4;
    localparam int BUDGET = 4000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        hSync, vSync;
    logic [11:0] rgb_in;
    logic [9:0]  probe_x, probe_y;
    logic        locked, rx_bright, pix_valid, probe_valid;
    logic [9:0]  rx_hc, rx_vc;
    logic [11:0] pix_rgb, probe_rgb;
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;
`ifdef VGA_RX_CRC_EN
    logic [15:0] frame_crc;
    logic        crc_valid;
    int          crc_cnt = 0;
`endif

    int checks = 0, failures = 0;
    int gen_v = 0, gen_h = 0, gen_sub = 0;
    int short_line = -1, frame_lines = VT;
    logic [11:0] bg = 12'h69C, hot = 12'hFFF;
    int pv_cnt = 0, pr_cnt = 0, pv_snap, pr_snap;

    vga_sync_receiver #(
        .CLKS_PER_PIX (CPP), .SAMPLE_PHASE (2),
        .H_TOTAL (HT), .H_VIS_START (HVS), .H_VIS (HV),
        .V_TOTAL (VT), .V_VIS_START (VVS), .V_VIS (VV)
    ) dut (
        .clk (clk), .reset_n (reset_n), .hSync (hSync), .vSync (vSync),
        .rgb_in (rgb_in), .probe_x (probe_x), .probe_y (probe_y),
        .locked (locked), .rx_hc (rx_hc), .rx_vc (rx_vc), .rx_bright (rx_bright),
        .pix_valid (pix_valid), .pix_rgb (pix_rgb),
        .probe_valid (probe_valid), .probe_rgb (probe_rgb),
        .frame_cnt (frame_cnt), .err_cnt (err_cnt)
`ifdef VGA_RX_CRC_EN
        , .frame_crc (frame_crc), .crc_valid (crc_valid)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pix_valid)   pv_cnt <= pv_cnt + 1;
        if (probe_valid) pr_cnt <= pr_cnt + 1;
`ifdef VGA_RX_CRC_EN
        if (crc_valid)   crc_cnt <= crc_cnt + 1;
`endif
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock of the raster generator: drive current position, then advance
    task automatic run_clocks(input int n);
        for (int k = 0; k < n; k++) begin
            hSync  = (gen_h < 3) ? 1'b0 : 1'b1;
            vSync  = (gen_v < 2) ? 1'b0 : 1'b1;
            rgb_in = (gen_h == 12 && gen_v == 7) ? hot : bg;
            @(posedge clk); #1;
            gen_sub++;
            if (gen_sub == CPP) begin
                gen_sub = 0;
                gen_h++;
                if (gen_h == ((gen_v == short_line) ? HT - 1 : HT)) begin
                    gen_h = 0;
                    gen_v++;
                    if (gen_v == frame_lines) gen_v = 0;
                end
            end
        end
    endtask

    task automatic run_to(input int line, input int px);
        int n = 0;
        do begin
            run_clocks(1);
            n++;
        end while (!(gen_v == line && gen_h == px && gen_sub == 0) && n < BUDGET);
        check("run_to_reached", (n < BUDGET), 1);
    endtask

    task automatic idle_clocks(input int n);
        hSync = 1'b1; vSync = 1'b1; rgb_in = '0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

`ifdef VGA_RX_CRC_EN
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [11:0] d);
        logic [15:0] r = c;
        for (int i = 11; i >= 0; i--)
            r = (r[15] ^ d[i]) ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
        return r;
    endfunction
`endif

    initial begin
        reset_n = 1'b0; hSync = 1'b1; vSync = 1'b1; rgb_in = '0;
        probe_x = 10'd7; probe_y = 10'd4;
        repeat (3) @(posedge clk);
        #1;
        check("rst_locked", locked, 0);
        check("rst_hc", rx_hc, 0);
        check("rst_vc", rx_vc, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_pix_valid", pix_valid, 0);
        reset_n = 1'b1;

        // Frame 1 enters ACQUIRE; lock appears two clocks into frame 2
        run_to(0, 0);
        run_clocks(1);
        check("lock_not_yet", locked, 0);
        run_clocks(1);
        check("lock_at_2nd_vs", locked, 1);
        check("coinc_hc", rx_hc, 0);
        check("coinc_vc", rx_vc, 0);
        pv_snap = pv_cnt; pr_snap = pr_cnt;

        run_to(3, 5); run_clocks(2);
        check("vis_hc", rx_hc, 5);
        check("vis_vc", rx_vc, 3);
        check("vis_bright", rx_bright, 1);
        run_clocks(48);
        check("hend_hc", rx_hc, 17);
        check("hend_bright", rx_bright, 0);
        run_to(11, 5); run_clocks(2);
        check("vend_bright", rx_bright, 0);

        run_to(0, 0); run_clocks(2);
        check("f3_frame_cnt", frame_cnt, 1);
        check("f3_err_cnt", err_cnt, 0);
        check("f2_pix_count", pv_cnt - pv_snap, HV * VV);
        check("f2_probe_count", pr_cnt - pr_snap, 1);
        check("f2_probe_rgb", probe_rgb, 12'hFFF);
        check("f2_last_pix", pix_rgb, 12'h69C);

        // Out-of-range probe column never fires
        probe_x = 10'd12;
        pv_snap = pv_cnt; pr_snap = pr_cnt;
        run_to(0, 0); run_clocks(2);
        check("f4_frame_cnt", frame_cnt, 2);
        check("oor_probe_count", pr_cnt - pr_snap, 0);
        check("f3_pix_count", pv_cnt - pv_snap, HV * VV);

        // Line 5 shortened to 19 pixels
        short_line = 5;
        run_to(6, 0);
        short_line = -1;
        run_clocks(1);
        check("short_still_locked", locked, 1);
        run_clocks(1);
        check("short_lock_lost", locked, 0);
        check("short_err_cnt", err_cnt, 1);
        check("short_vc", rx_vc, 6);
        pv_snap = pv_cnt;
        run_to(0, 0); run_clocks(2);
        check("relock_acquire", locked, 0);
        run_to(0, 0); run_clocks(2);
        check("relock_locked", locked, 1);
        check("relock_frame_cnt", frame_cnt, 2);
        check("no_pix_while_unlocked", pv_cnt - pv_snap, 0);

        probe_x = 10'd7;
        pr_snap = pr_cnt;
        run_to(0, 0); run_clocks(2);
        check("f7_frame_cnt", frame_cnt, 3);
        check("f6_probe_count", pr_cnt - pr_snap, 1);

        // 11-line frame: coincident syncs with rx_vc=10 -> frame error
        frame_lines = 11;
        run_to(0, 0);
        frame_lines = VT;
        run_clocks(1);
        check("frame_err_still_locked", locked, 1);
        run_clocks(1);
        check("frame_err_lock_lost", locked, 0);
        check("frame_err_err_cnt", err_cnt, 2);
        check("frame_err_vc", rx_vc, 0);

        run_to(0, 0); run_to(0, 0); run_clocks(2);
        check("relock2_locked", locked, 1);

        // Asynchronous reset mid-line
        run_to(5, 8);
        reset_n = 1'b0;
        #1;
        check("arst_locked", locked, 0);
        check("arst_hc", rx_hc, 0);
        check("arst_vc", rx_vc, 0);
        check("arst_frame_cnt", frame_cnt, 0);
        check("arst_err_cnt", err_cnt, 0);
        check("arst_probe_rgb", probe_rgb, 0);
        check("arst_pix_rgb", pix_rgb, 0);
        idle_clocks(3);
        reset_n = 1'b1;
        idle_clocks(100);
        check("hc_saturates", rx_hc, HT - 1);
        pv_snap = pv_cnt;
        run_to(0, 0); run_clocks(2);
        check("arst_acquire", locked, 0);
        run_to(0, 0); run_clocks(2);
        check("arst_relock", locked, 1);
        check("arst_no_pix", pv_cnt - pv_snap, 0);

`ifdef VGA_RX_CRC_EN
        begin
            logic [15:0] gold;
            int          cs;
            bg = 12'h000; hot = 12'h000;
            cs = crc_cnt;
            gold = 16'hFFFF;
            for (int i = 0; i < HV * VV; i++) gold = crc_step(gold, 12'h000);
            run_to(0, 0); run_clocks(2);
            check("crc_zero_frame", frame_crc, gold);
            check("crc_valid_count", crc_cnt - cs, 1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
